// File: rtl/fft_output_reader.sv
// fft_output_reader: captures 4-lane FFT last-stage beats into a bit-reversed
// buffer and streams the finished frame out in natural order over valid/ready.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, data_in0..3 - capture side; one 4-word beat per in_valid cycle
//   out_valid, out_ready, out_data, out_index, out_last - drain handshake
//   busy                - frame is draining; input beats are refused
//   frame_done          - one-cycle pulse after the final word's handshake
//   overflow, clr_err   - sticky "beat arrived while busy" flag and its clear
module fft_output_reader #(
    parameter int WORDSIZE   = 16,
    parameter int ADDRSIZE   = 8,
    parameter int NUMSAMPLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WORDSIZE-1:0] data_in0,
    input  logic [WORDSIZE-1:0] data_in1,
    input  logic [WORDSIZE-1:0] data_in2,
    input  logic [WORDSIZE-1:0] data_in3,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_data,
    output logic [ADDRSIZE-1:0] out_index,
    output logic                out_last,
    output logic                frame_done,
    output logic                overflow,
    input  logic                clr_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDRSIZE-3:0] r_beat;
    logic [ADDRSIZE-1:0] r_rd;
    logic                r_prime;
    logic [WORDSIZE-1:0] r_mem [NUMSAMPLES];

    logic                w_cap;
    logic                w_hs;
    logic                w_done;
    logic [WORDSIZE-1:0] w_lane [4];

    function automatic logic [ADDRSIZE-1:0] f_bitrev(
        input logic [ADDRSIZE-1:0] n
    );
        logic [ADDRSIZE-1:0] r;
        for (int i = 0; i < ADDRSIZE; i++) begin
            r[ADDRSIZE-1-i] = n[i];
        end
        return r;
    endfunction

    assign w_lane[0] = data_in0;
    assign w_lane[1] = data_in1;
    assign w_lane[2] = data_in2;
    assign w_lane[3] = data_in3;

    // Beats are only taken outside DRAIN; a beat during DRAIN is an overflow.
    assign busy   = (r_state == S_DRAIN);
    assign w_cap  = in_valid && !busy;
    assign w_hs   = out_valid && out_ready;
    assign w_done = w_hs && out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_cap) begin
                    w_next = (r_beat == '1) ? S_DRAIN : S_FILL;
                end
            end
            S_DRAIN: begin
                if (w_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Lane j of beat k is sample n = 4k+j; it lands at bitrev(n) so that
    // a linear read of the buffer yields natural order.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int j = 0; j < 4; j++) begin
                r_mem[f_bitrev({r_beat, 2'(j)})] <= w_lane[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_rd       <= '0;
            r_prime    <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= w_done;

            // A new overflow event beats a simultaneous clear.
            if (in_valid && busy) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            // Counter wraps to 0 on the final beat, ready for the next frame.
            if (w_cap) begin
                r_beat <= r_beat + 1'b1;
            end

            if (busy) begin
                if (w_done) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    r_prime   <= 1'b0;
                    r_rd      <= '0;
                end else if (w_hs || (r_prime && !out_valid)) begin
                    // Load next word: first one after the settle cycle,
                    // then one per accepted handshake.
                    out_valid <= 1'b1;
                    out_data  <= r_mem[r_rd];
                    out_index <= r_rd;
                    out_last  <= (r_rd == '1);
                    r_rd      <= r_rd + 1'b1;
                end else begin
                    // First DRAIN cycle is a settle cycle, putting the
                    // first word two edges after the final capture.
                    r_prime <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reader.sv
// tb_fft_output_reader: randomized self-checking bench for fft_output_reader.
// Reference model: natural-order word m equals captured sample bitrev(m).
module tb_fft_output_reader;

    localparam int W = 16;
    localparam int A = 8;
    localparam int N = 256;
    localparam int B = N / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [A-1:0] out_index;
    logic         out_last;
    logic         frame_done;
    logic         overflow;
    logic         clr_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] cap  [N];
    logic [W-1:0] gold [N];

    always #5 clk = ~clk;

    fft_output_reader #(
        .WORDSIZE  (W),
        .ADDRSIZE  (A),
        .NUMSAMPLES(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in0  (d0),
        .data_in1  (d1),
        .data_in2  (d2),
        .data_in3  (d3),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_done(frame_done),
        .overflow  (overflow),
        .clr_err   (clr_err)
    );

    function automatic int bitrev(input int n);
        int r = 0;
        for (int i = 0; i < A; i++) begin
            if (((n >> i) & 1) != 0) r = r | (1 << (A - 1 - i));
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        clr_err  = 1'b0;
        d0 = 'x;
        d1 = 'x;
        d2 = 'x;
        d3 = 'x;
    endtask

    task automatic check_quiet(input string tag);
        n_cmp++;
        if ({out_valid, busy, frame_done, out_last} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s_quiet: valid/busy/fd/last=%b want 0000", tag,
                     {out_valid, busy, frame_done, out_last});
        end
    endtask

    // Drive one frame of beats; sample n = 4k+j. rst_beat>=0 aborts there.
    task automatic run_fill(input bit rnd, input logic [W-1:0] base,
                            input int gmin, input int gmax,
                            input int rst_beat);
        for (int k = 0; k < B; k++) begin
            int g = $urandom_range(gmax, gmin);
            repeat (g) begin
                idle_inputs();
                tick();
            end
            for (int j = 0; j < 4; j++) begin
                cap[4*k+j] = rnd ? W'($urandom) : base + W'(4*k+j);
            end
            in_valid = 1'b1;
            d0 = cap[4*k];
            d1 = cap[4*k+1];
            d2 = cap[4*k+2];
            d3 = cap[4*k+3];
            if (k == rst_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                idle_inputs();
                return;
            end
            tick();
        end
        idle_inputs();
        for (int m = 0; m < N; m++) gold[m] = cap[bitrev(m)];
    endtask

    // Consume one frame starting the cycle after the final capture.
    task automatic run_drain(input bit rnd, input bit inject,
                             input int rst_word);
        int m = 0;
        int cyc = 0;
        int first = -1;
        int lasths = 0;
        int fd = 0;
        int low = 0;
        int exp_ovf = -1;
        bit done = 0;
        bit pv = 0;
        bit pr = 0;
        logic [W-1:0] pd = '0;
        logic [A-1:0] pi = '0;
        logic pl = 1'b0;
        while (!done && cyc < 5000) begin
            idle_inputs();
            if (exp_ovf >= 0) begin
                n_cmp++;
                if (overflow !== 1'(exp_ovf)) begin
                    n_err++;
                    $display("FAIL ovf_at_%0d: overflow=%b want %0d",
                             m, overflow, exp_ovf);
                end
                exp_ovf = -1;
            end
            if (cyc == 0) begin
                n_cmp++;
                if (busy !== 1'b1 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL drain_entry: busy=%b ovf=%b want 1 0",
                             busy, overflow);
                end
            end
            if (frame_done === 1'b1) fd++;
            if (first < 0 && out_valid === 1'b1) begin
                first = cyc;
                n_cmp++;
                if (cyc != 2) begin
                    n_err++;
                    $display("FAIL latency: first valid at %0d want 2", cyc);
                end
            end
            if (pv && !pr) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== pd ||
                    out_index !== pi || out_last !== pl) begin
                    n_err++;
                    $display("FAIL stall: v=%b d=%h i=%0d l=%b want 1 %h %0d %b",
                             out_valid, out_data, out_index, out_last,
                             pd, pi, pl);
                end
            end
            if (rnd) begin
                if (low > 0) begin
                    out_ready = 1'b0;
                    low--;
                end else if ($urandom_range(15, 0) == 0) begin
                    out_ready = 1'b0;
                    low = 4;
                end else begin
                    out_ready = 1'($urandom_range(1, 0));
                end
            end else begin
                out_ready = 1'b1;
            end
            if (rst_word >= 0 && m == rst_word) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_quiet("rst_drain");
                n_cmp++;
                if (overflow !== 1'b0 || out_data !== '0) begin
                    n_err++;
                    $display("FAIL rst_drain_regs: ovf=%b data=%h want 0 0",
                             overflow, out_data);
                end
                return;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (out_data !== gold[m] || out_index !== A'(m) ||
                    out_last !== (m == N - 1)) begin
                    n_err++;
                    $display("FAIL word_%0d: d=%h i=%0d l=%b want %h %0d %b",
                             m, out_data, out_index, out_last, gold[m], m,
                             (m == N - 1));
                end
                if (inject) begin
                    if (m == 10 || m == 20 || m == N - 1) begin
                        in_valid = 1'b1;
                        d0 = 16'hDEAD;
                        d1 = 16'hDEAD;
                        d2 = 16'hDEAD;
                        d3 = 16'hDEAD;
                        exp_ovf = 1;
                    end
                    if (m == 15 || m == 20 || m == 30) clr_err = 1'b1;
                    if (m == 15 || m == 30) exp_ovf = 0;
                end
                if (m == N - 1) begin
                    done = 1;
                    lasths = cyc;
                end
                m++;
            end
            pv = (out_valid === 1'b1);
            pr = out_ready;
            pd = out_data;
            pi = out_index;
            pl = out_last;
            tick();
            cyc++;
        end
        idle_inputs();
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words want %0d", m, N);
            return;
        end
        if (!rnd) begin
            n_cmp++;
            if (lasths - first + 1 != N) begin
                n_err++;
                $display("FAIL throughput: span %0d want %0d",
                         lasths - first + 1, N);
            end
        end
        n_cmp++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            fd != 0) begin
            n_err++;
            $display("FAIL frame_end: fd=%b v=%b busy=%b early=%0d want 1 0 0 0",
                     frame_done, out_valid, busy, fd);
        end
        n_cmp++;
        if (overflow !== 1'(inject)) begin
            n_err++;
            $display("FAIL end_ovf: overflow=%b want %b", overflow, inject);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        repeat (3) tick();
        check_quiet("reset");
        n_cmp++;
        if (overflow !== 1'b0 || out_data !== '0 || out_index !== '0) begin
            n_err++;
            $display("FAIL reset_regs: ovf=%b d=%h i=%0d want 0 0 0",
                     overflow, out_data, out_index);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        run_fill(0, 16'h0000, 0, 0, -1);
        run_drain(0, 0, -1);
        tick();
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL fd_width: frame_done=%b want 0", frame_done);
        end
        repeat (2) tick();
    endtask

    task automatic test_latency_gaps();
        run_fill(0, 16'h0000, 3, 3, -1);
        run_drain(0, 0, -1);
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 2; f++) begin
            run_fill(1, 16'h0000, 0, 3, -1);
            run_drain(1, 0, -1);
            repeat (2) tick();
        end
    endtask

    task automatic test_overflow();
        run_fill(0, 16'h0000, 0, 0, -1);
        run_drain(0, 1, -1);
        repeat (3) tick();
        n_cmp++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf=%b busy=%b want 1 0",
                     overflow, busy);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: overflow=%b want 0", overflow);
        end
        run_fill(1, 16'h0000, 0, 2, -1);
        run_drain(0, 0, -1);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        run_fill(0, 16'h0000, 0, 1, 30);
        check_quiet("rst_fill");
        repeat (2) tick();
        run_fill(0, 16'h0000, 0, 0, -1);
        run_drain(0, 0, -1);
        repeat (2) tick();
        run_fill(0, 16'h0000, 0, 0, -1);
        run_drain(1, 0, 100);
        repeat (2) tick();
        run_fill(1, 16'h0000, 0, 1, -1);
        run_drain(0, 0, -1);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        run_fill(0, 16'h0000, 0, 0, -1);
        run_drain(0, 0, -1);
        run_fill(0, 16'h0100, 0, 0, -1);
        run_drain(0, 0, -1);
        run_fill(1, 16'h0000, 0, 0, -1);
        run_drain(1, 0, -1);
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_latency_gaps();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_output_reader.md
Name: fft_output_reader

Overview:
- Consumer end of the FFT last-stage output interface.
- Captures the four parallel result buses (data_in0..3) whenever the last stage flags valid output, for one full frame of NUMSAMPLES samples.
- Undoes the radix-4 digit/bit-reversed ordering by writing each sample to its bit-reversed address in an internal buffer.
- Streams the frame out serially, in natural order, over a valid/ready handshake to downstream logic (host or test harness).

Parameters:
- WORDSIZE, 16: width of each sample word.
- ADDRSIZE, 8: log2(NUMSAMPLES); sample index width.
- NUMSAMPLES, 256: samples per frame; must equal 2**ADDRSIZE and be a multiple of 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  last stage presents 4 valid words this cycle; driven from the last stage's all_done.
- data_in0  input  WORDSIZE  lane 0 result; may be high-Z when in_valid=0.
- data_in1  input  WORDSIZE  lane 1 result.
- data_in2  input  WORDSIZE  lane 2 result.
- data_in3  input  WORDSIZE  lane 3 result.
- busy  output  1  high in DRAIN; input beats are not accepted.
- out_valid  output  1  out_data/out_index valid.
- out_ready  input  1  downstream accepts the current word.
- out_data  output  WORDSIZE  natural-order sample.
- out_index  output  ADDRSIZE  natural-order index m of out_data.
- out_last  output  1  high with out_valid when out_index = NUMSAMPLES-1.
- frame_done  output  1  one-cycle pulse on the handshake of the last word.
- overflow  output  1  sticky error flag; cleared only by rst or clr_err.
- clr_err  input  1  synchronous clear of overflow.

Behaviour:
- Reset: all outputs are 0 (out_valid, out_last, frame_done, overflow, busy, out_data, out_index). State = IDLE, beat counter = 0, read counter = 0. Buffer contents are don't-care. Reset asserted mid-FILL or mid-DRAIN aborts the frame immediately; the partial frame is discarded.
- States:
  - IDLE: in_valid=1 -> capture beat 0 and go to FILL.
  - FILL: each in_valid=1 cycle captures one beat. When the captured beat is beat NUMSAMPLES/4-1 -> go to DRAIN.
  - DRAIN: on the out_valid && out_ready handshake with out_last=1 -> go to IDLE.
- in_valid=0 in FILL: hold; no timeout. Beats need not be contiguous.
- Capture, beat k (0..NUMSAMPLES/4-1), lane j (0..3):
  - n = 4k + j (ADDRSIZE bits).
  - data_in_j is written to buffer address bitrev(n), with bit i of n moved to bit ADDRSIZE-1-i.
  - All 4 lanes are written in the same cycle; the buffer is organised as 4 banks or a 4-write-port equivalent.
  - data_in lines are sampled only when in_valid=1; X/Z on the lines at other times must not affect state.
- Drain:
  - Reads addresses m = 0..NUMSAMPLES-1 in order; out_data = buffer[m], out_index = m.
  - out_valid first rises exactly 2 cycles after the edge that captured the final beat.
  - Standard valid/ready: once out_valid=1, out_data, out_index and out_last hold stable until out_ready=1 is sampled.
  - With out_ready held at 1, one word transfers per cycle with no bubbles; a full drain takes NUMSAMPLES cycles.
  - out_ready is ignored while out_valid=0.
- frame_done: pulses 1 cycle, coincident with the edge after the out_last handshake. out_valid is 0 in that cycle.
- busy: 1 from the cycle after the final beat capture until the cycle after the last handshake.
- Overflow:
  - in_valid=1 while in DRAIN sets overflow=1; the beat is dropped and drain continues unaffected.
  - in_valid=1 on the same cycle DRAIN completes is also overflow, because busy is still 1.
  - clr_err and a new overflow event in the same cycle: the set wins.
- Back-to-back frames: a new frame may start capturing the cycle after frame_done, i.e. the first cycle busy=0.
- Width rules: beat counter is ADDRSIZE-2 bits and wraps naturally at end of frame. Read counter is ADDRSIZE bits. Data is passed through unmodified; no arithmetic on samples.

Test Plan:
- Ramp frame: drive 64 contiguous beats with lane j of beat k = 4k+j, out_ready=1 -> 256 words out. out_data(m) = bitrev8(m): m=0->0, m=1->0x80, m=2->0x40, m=3->0xC0, m=255->0xFF. out_last only at m=255; frame_done pulses once.
- Latency/throughput: same frame, in_valid gaps of 3 cycles between beats -> out_valid rises exactly 2 cycles after the 64th capture. 256 consecutive transfers follow with no bubbles.
- Backpressure: toggle out_ready randomly (including 5-cycle low stretches) -> out_data/out_index stable while stalled. All 256 values are correct and in order; no duplicates or skips.
- Overflow: assert in_valid at drain word 10 with data 0xDEAD -> overflow=1 and stays 1. Drained data is unchanged. clr_err -> overflow=0 the next cycle.
- Reset mid-operation: rst during FILL at beat 30, then a fresh full ramp frame -> output matches the ramp golden exactly. Repeat with rst at drain word 100 -> out_valid=0 on the cycle after rst.
- Back-to-back: frame A = ramp, frame B = ramp+0x100, with B's first beat on the cycle after A's frame_done -> both frames drain correctly and overflow remains 0.
